// File: rtl/multi_ch_sync_rx_pkg.sv
// Shared helpers for the multi-channel toggle-handshake receiver.
package multi_ch_sync_rx_pkg;

  // Ceiling log2, written as a bounded loop so it folds as a constant.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // Channel index width; a single channel still gets one bit.
  function automatic int ch_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/multi_ch_sync_rx_sync_chain.sv
// Multi-bit flop synchroniser; each bit is an independent request line.
module multi_ch_sync_rx_sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [STAGES-1:0][WIDTH-1:0] ff_q;

  // Shift the asynchronous level through STAGES flops; entry 0 is the metastable one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ff_q <= '0;
    else       ff_q <= {ff_q[STAGES-2:0], async_in};
  end

  assign sync_out = ff_q[STAGES-1];

endmodule

// File: rtl/multi_ch_sync_rx.sv
// Receive side of a toggle-handshake CDC: synchronise per-channel request toggles,
// capture each channel's word, and merge channels round-robin onto one stream.
module multi_ch_sync_rx
  import multi_ch_sync_rx_pkg::*;
#(
  parameter int  WIDTH  = 16,
  parameter int  NUM_CH = 4,
  parameter int  STAGES = 2,
  localparam int CHW    = ch_w(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       req_tgl,
  input  logic [NUM_CH*WIDTH-1:0] data,
  output logic [NUM_CH-1:0]       ack_tgl,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [CHW-1:0]          out_ch,
  output logic [NUM_CH-1:0]       err,
  input  logic [NUM_CH-1:0]       err_clr
);

  logic [NUM_CH-1:0]            req_s, dly_q, req_ed, cap, ovr, gnt_oh;
  logic [NUM_CH-1:0]            pend_q, pend_d, ack_q, ack_d, err_q, err_d;
  logic [NUM_CH-1:0][WIDTH-1:0] data_w, hold_q;
  logic [CHW-1:0]               rr_q, rr_d, gnt_idx, out_ch_q;
  logic [WIDTH-1:0]             gnt_word, out_data_q;
  logic                         gnt_vld, stage_free, out_valid_q;
  int                           best, off;

  assign data_w = data;

  multi_ch_sync_rx_sync_chain #(
    .WIDTH (NUM_CH),
    .STAGES(STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_in(req_tgl),
    .sync_out(req_s)
  );

  // A toggle in either direction is a new request; a busy hold register drops it.
  assign req_ed     = req_s ^ dly_q;
  assign cap        = req_ed & ~pend_q;
  assign ovr        = req_ed & pend_q;
  assign stage_free = ~out_valid_q | out_ready;

  // Round-robin pick: the pending channel at the smallest upward distance from rr.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    gnt_word = '0;
    best     = NUM_CH;
    off      = 0;
    for (int j = 0; j < NUM_CH; j++) begin
      off = (j + NUM_CH - int'(rr_q)) % NUM_CH;
      if (pend_q[j] && off < best) begin
        best     = off;
        gnt_idx  = CHW'(j);
        gnt_word = hold_q[j];
        gnt_vld  = 1'b1;
      end
    end
  end

  // Per-channel next state: grant releases the hold and toggles ack; errors are sticky.
  always_comb begin
    gnt_oh = '0;
    if (stage_free && gnt_vld) gnt_oh[gnt_idx] = 1'b1;
    pend_d = (pend_q & ~gnt_oh) | cap;
    ack_d  = ack_q ^ gnt_oh;
    err_d  = (err_q & ~err_clr) | ovr;
    rr_d   = rr_q;
    if (stage_free && gnt_vld)
      rr_d = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + CHW'(1);
  end

  // State registers, hold capture and the output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dly_q       <= '0;
      pend_q      <= '0;
      ack_q       <= '0;
      err_q       <= '0;
      rr_q        <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      dly_q  <= req_s;
      pend_q <= pend_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
      rr_q   <= rr_d;
      for (int c = 0; c < NUM_CH; c++)
        if (cap[c]) hold_q[c] <= data_w[c];
      if (stage_free) begin
        out_valid_q <= gnt_vld;
        if (gnt_vld) begin
          out_data_q <= gnt_word;
          out_ch_q   <= gnt_idx;
        end
      end
    end
  end

  assign ack_tgl   = ack_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign err       = err_q;

endmodule
